// File: rtl/uart_rx_pkg.sv
// Shared UART RX constants: legal oversampling ratios, idle line level and
// default counter widths used by the RX oversampling stage and its counters.
package uart_rx_pkg;

    // Default widths: prescale up to 32 needs 6 bits, frame of up to 16 slots
    localparam int unsigned PRESCALE_W = 6;
    localparam int unsigned BIT_CNT_W  = 4;

    // Legal oversampling ratios
    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Level of an idle (marking) RX line
    localparam logic RX_IDLE_LVL = 1'b1;

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and bit-slot counter for the UART RX path.
// edge_cnt runs 0..prescale-1 within a bit; on wrap bit_cnt advances and
// wraps modulo 2^BIT_CNT_W. The wrap test is ">=" so a prescale decrease
// below the current edge_cnt wraps on the next clock instead of locking up.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int unsigned BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    // One extra bit so prescale=0 (and prescale-1 underflow) needs no special case
    logic [PRESCALE_W:0]   edge_inc;

    // Next-state: clear when disabled, wrap at prescale-1, else increment
    always_comb begin
        edge_inc   = {1'b0, edge_cnt_q} + {{PRESCALE_W{1'b0}}, 1'b1};
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!cnt_en) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (edge_inc >= {1'b0, prescale}) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        end else begin
            edge_cnt_d = edge_inc[PRESCALE_W-1:0];
        end
    end

    // Counter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/data_sampling.sv
// UART RX oversampling stage: counts edges/bits and takes a 3-sample
// majority vote around the bit centre (mid-1, mid, mid+1 with mid=prescale>>1).
// sampled_bit updates one clock after edge mid+1, with sample_valid high for
// exactly that following cycle.
// Build option DATA_SAMPLING_SYNC_EN: rx_in goes through a 2-flop synchronizer
// (reset to idle) before the vote logic, adding 2 clocks from pin to vote.
module data_sampling
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int unsigned BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cnt_en,
    input  logic                  dat_samp_en,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    logic                  rx_samp;
    logic [PRESCALE_W-1:0] mid, mid_m1, mid_p1;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  sample_valid_q, sample_valid_d;

`ifdef DATA_SAMPLING_SYNC_EN
    logic [1:0] rx_sync_q;

    // Two-flop synchronizer, reset to idle so no false start is seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_q <= {2{RX_IDLE_LVL}};
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_in};
        end
    end

    assign rx_samp = rx_sync_q[1];
`else
    assign rx_samp = rx_in;
`endif

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_edge_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en),
        .prescale (prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    // Sample points around the bit centre; only meaningful for prescale >= 4
    always_comb begin
        mid    = prescale >> 1;
        mid_m1 = mid - PRESCALE_W'(1);
        mid_p1 = mid + PRESCALE_W'(1);
    end

    // Vote next-state: capture s0/s1, then vote with the live third sample
    always_comb begin
        s0_d           = s0_q;
        s1_d           = s1_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
        if (dat_samp_en) begin
            if (edge_cnt == mid_m1) begin
                s0_d = rx_samp;
            end
            if (edge_cnt == mid) begin
                s1_d = rx_samp;
            end
            if (edge_cnt == mid_p1) begin
                sampled_bit_d  = (s0_q & s1_q) | (s0_q & rx_samp) | (s1_q & rx_samp);
                sample_valid_d = 1'b1;
            end
        end
    end

    // Vote and output registers; idle-level reset keeps downstream quiet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q           <= RX_IDLE_LVL;
            s1_q           <= RX_IDLE_LVL;
            sampled_bit_q  <= RX_IDLE_LVL;
            sample_valid_q <= 1'b0;
        end else begin
            s0_q           <= s0_d;
            s1_q           <= s1_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;

endmodule
